// File: rtl/hazard_ctrl_param_if.sv
// hazard_ctrl_param_if: pipeline hazard-unit signal bundle between datapath and hazard controller
interface hazard_ctrl_param_if #(
    parameter int AW   = 4,
    parameter int NSRC = 2,
    parameter int CW   = 16
);
    logic [NSRC*AW-1:0] i_ra_id;
    logic [AW-1:0]      i_wa_ex;
    logic [AW-1:0]      i_wa_mem;
    logic [AW-1:0]      i_wa_wb;
    logic               i_regwrite_e;
    logic               i_regwrite_m;
    logic               i_regwrite_w;
    logic               i_memtoreg_e;
    logic               i_branch_e;
    logic               i_mem_busy;
    logic               i_cnt_clr;
    logic [2*NSRC-1:0]  o_fwd;
    logic               o_stall_f;
    logic               o_stall_d;
    logic               o_stall_e;
    logic               o_flush_d;
    logic               o_flush_e;
    logic [1:0]         o_state;
    logic [CW-1:0]      o_stall_cnt;

    modport master (
        output i_ra_id, i_wa_ex, i_wa_mem, i_wa_wb,
        output i_regwrite_e, i_regwrite_m, i_regwrite_w,
        output i_memtoreg_e, i_branch_e, i_mem_busy, i_cnt_clr,
        input  o_fwd, o_stall_f, o_stall_d, o_stall_e,
        input  o_flush_d, o_flush_e, o_state, o_stall_cnt
    );

    modport slave (
        input  i_ra_id, i_wa_ex, i_wa_mem, i_wa_wb,
        input  i_regwrite_e, i_regwrite_m, i_regwrite_w,
        input  i_memtoreg_e, i_branch_e, i_mem_busy, i_cnt_clr,
        output o_fwd, o_stall_f, o_stall_d, o_stall_e,
        output o_flush_d, o_flush_e, o_state, o_stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: forwarding select, load-use/memory-wait stalls and branch flush control
module hazard_ctrl_param #(
    parameter int AW        = 4,
    parameter int NSRC      = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CW        = 16,
    parameter int ZERO_REG  = 0
) (
    input logic               clk,
    input logic               rst_n,
    hazard_ctrl_param_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        MEMWAIT = 2'b10,
        FLUSH   = 2'b11
    } state_t;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [2*NSRC-1:0] fwd_q, fwd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              load_use;
    logic              stall_f, stall_d, stall_e, flush_d, flush_e;

    function automatic logic hit(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic we);
        return we && (ra == wa) && !(ZERO_REG != 0 && ra == '0);
    endfunction

    // Control outputs are a pure decode of the registered state
    assign stall_f = (state_q == LDSTALL) || (state_q == MEMWAIT);
    assign stall_d = stall_f;
    assign stall_e = (state_q == MEMWAIT);
    assign flush_d = (state_q == FLUSH);
    assign flush_e = (state_q == FLUSH) || (state_q == LDSTALL);

    // Load-use: any ID source produced by a load still in EX
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NSRC; k++)
            load_use = load_use | hit(bus.i_ra_id[k*AW +: AW], bus.i_wa_ex, bus.i_regwrite_e);
        load_use = load_use & bus.i_memtoreg_e;
    end

    // Forward select: held while ID is stalled (its operands still need it), cleared on EX bubble, else MEM beats WB
    always_comb begin
        fwd_d = fwd_q;
        if (!stall_d && flush_e)
            fwd_d = '0;
        else if (!stall_d)
            for (int k = 0; k < NSRC; k++)
                fwd_d[2*k +: 2] = hit(bus.i_ra_id[k*AW +: AW], bus.i_wa_mem, bus.i_regwrite_m) ? 2'b01 :
                                  hit(bus.i_ra_id[k*AW +: AW], bus.i_wa_wb,  bus.i_regwrite_w) ? 2'b10 : 2'b00;
    end

    // Next state; LDSTALL lasts one cycle and then applies the RUN priorities directly
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            MEMWAIT: state_d = bus.i_mem_busy ? MEMWAIT : RUN;
            FLUSH: begin
                if (bus.i_branch_e)
                    fcnt_d = FLUSH_LD;
                else if (fcnt_q <= 4'd1) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else
                    fcnt_d = fcnt_q - 4'd1;
            end
            default: begin
                if (bus.i_branch_e) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LD;
                end else if (bus.i_mem_busy)
                    state_d = MEMWAIT;
                else if (load_use)
                    state_d = LDSTALL;
                else
                    state_d = RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter; clear beats increment
    always_comb begin
        cnt_d = bus.i_cnt_clr ? '0 :
                ((stall_f || stall_d || stall_e) && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            fwd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fwd_q   <= fwd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_fwd       = fwd_q;
    assign bus.o_stall_f   = stall_f;
    assign bus.o_stall_d   = stall_d;
    assign bus.o_stall_e   = stall_e;
    assign bus.o_flush_d   = flush_d;
    assign bus.o_flush_e   = flush_e;
    assign bus.o_state     = state_q;
    assign bus.o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed vectors and multi-cycle sequences for hazard_ctrl_param
module tb_hazard_ctrl_param;
    typedef struct packed {
        logic [7:0] ra;
        logic [3:0] wa_ex;
        logic [3:0] wa_mem;
        logic [3:0] wa_wb;
        logic [2:0] rw;
        logic [3:0] ctl;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [3:0] fwd;
        logic [1:0] st;
        logic [4:0] fl;
        logic [3:0] cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    in_t  cur;
    int   n_chk;
    int   n_fail;
    vec_t vecs[10];

    hazard_ctrl_param_if #(.AW(4), .NSRC(2), .CW(4)) bus ();

    hazard_ctrl_param #(.AW(4), .NSRC(2), .FLUSH_CYC(2), .CW(4), .ZERO_REG(0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    assign bus.i_ra_id      = cur.ra;
    assign bus.i_wa_ex      = cur.wa_ex;
    assign bus.i_wa_mem     = cur.wa_mem;
    assign bus.i_wa_wb      = cur.wa_wb;
    assign bus.i_regwrite_e = cur.rw[2];
    assign bus.i_regwrite_m = cur.rw[1];
    assign bus.i_regwrite_w = cur.rw[0];
    assign bus.i_memtoreg_e = cur.ctl[3];
    assign bus.i_branch_e   = cur.ctl[2];
    assign bus.i_mem_busy   = cur.ctl[1];
    assign bus.i_cnt_clr    = cur.ctl[0];

    wire [4:0] flags = {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_flush_d, bus.o_flush_e};

    always #5 clk = ~clk;

    // rw = {regwrite_e, regwrite_m, regwrite_w}; ctl = {memtoreg_e, branch_e, mem_busy, cnt_clr}
    function automatic in_t fi(input logic [7:0] ra, input logic [3:0] ex, input logic [3:0] mem,
                               input logic [3:0] wb, input logic [2:0] rw, input logic [3:0] ctl);
        in_t r;
        r.ra = ra; r.wa_ex = ex; r.wa_mem = mem; r.wa_wb = wb; r.rw = rw; r.ctl = ctl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] fwd, input logic [1:0] st,
                           input logic [4:0] fl, input logic [3:0] cnt);
        chk({nm, ".fwd"},   16'(bus.o_fwd),       16'(fwd));
        chk({nm, ".state"}, 16'(bus.o_state),     16'(st));
        chk({nm, ".flags"}, 16'(flags),           16'(fl));
        chk({nm, ".cnt"},   16'(bus.o_stall_cnt), 16'(cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clk    = 0;
        rst_n  = 1;
        cur    = '0;
        vecs[0] = '{fi(8'h03, 4'd0, 4'd3, 4'd3, 3'b011, 4'b0000), 4'b0001, 2'd0, 5'b0, 4'd0};
        vecs[1] = '{fi(8'h73, 4'd0, 4'd3, 4'd3, 3'b001, 4'b0000), 4'b0010, 2'd0, 5'b0, 4'd0};
        vecs[2] = '{fi(8'h92, 4'd0, 4'd9, 4'd2, 3'b011, 4'b0000), 4'b0110, 2'd0, 5'b0, 4'd0};
        vecs[3] = '{fi(8'h44, 4'd0, 4'd4, 4'd0, 3'b010, 4'b0000), 4'b0101, 2'd0, 5'b0, 4'd0};
        vecs[4] = '{fi(8'h66, 4'd0, 4'd6, 4'd6, 3'b001, 4'b0000), 4'b1010, 2'd0, 5'b0, 4'd0};
        vecs[5] = '{fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b010, 4'b0000), 4'b0101, 2'd0, 5'b0, 4'd0};
        vecs[6] = '{fi(8'h55, 4'd5, 4'd5, 4'd5, 3'b000, 4'b1000), 4'b0000, 2'd0, 5'b0, 4'd0};
        vecs[7] = '{fi(8'h05, 4'd5, 4'd0, 4'd0, 3'b100, 4'b0000), 4'b0000, 2'd0, 5'b0, 4'd0};
        vecs[8] = '{fi(8'h21, 4'd0, 4'd1, 4'd2, 3'b011, 4'b0000), 4'b1001, 2'd0, 5'b0, 4'd0};
        vecs[9] = '{fi(8'hFF, 4'd0, 4'hF, 4'hF, 3'b011, 4'b0000), 4'b0101, 2'd0, 5'b0, 4'd0};

        #1 rst_n = 0;
        #2 chk_all("reset", 4'b0, 2'd0, 5'b0, 4'd0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            cur = vecs[i].in;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].fwd, vecs[i].st, vecs[i].fl, vecs[i].cnt);
        end

        cur = fi(8'h50, 4'd5, 4'd0, 4'd0, 3'b100, 4'b1000);
        step(); chk_all("lu", 4'b0, 2'd1, 5'b11001, 4'd0);
        cur = '0;
        step(); chk_all("lu_exit", 4'b0, 2'd0, 5'b0, 4'd1);
        cur = fi(8'h50, 4'd5, 4'd0, 4'd0, 3'b100, 4'b1000);
        step(); chk_all("lu2a", 4'b0, 2'd1, 5'b11001, 4'd1);
        step(); chk_all("lu2b", 4'b0, 2'd1, 5'b11001, 4'd2);
        cur = '0;
        step(); chk_all("lu2_exit", 4'b0, 2'd0, 5'b0, 4'd3);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0001);
        step(); chk_all("clr", 4'b0, 2'd0, 5'b0, 4'd0);

        cur = fi(8'h03, 4'd0, 4'd3, 4'd0, 3'b010, 4'b0100);
        step(); chk_all("br", 4'b0001, 2'd3, 5'b00011, 4'd0);
        cur = fi(8'h03, 4'd0, 4'd3, 4'd0, 3'b010, 4'b0000);
        step(); chk_all("fl1", 4'b0, 2'd3, 5'b00011, 4'd0);
        step(); chk_all("fl2", 4'b0, 2'd0, 5'b0, 4'd0);
        step(); chk_all("fl_run", 4'b0001, 2'd0, 5'b0, 4'd0);

        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0100);
        step(); chk_all("db1", 4'b0, 2'd3, 5'b00011, 4'd0);
        step(); chk_all("db2", 4'b0, 2'd3, 5'b00011, 4'd0);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0010);
        step(); chk_all("db3", 4'b0, 2'd3, 5'b00011, 4'd0);
        step(); chk_all("db_exit", 4'b0, 2'd0, 5'b0, 4'd0);
        step(); chk_all("db_mw", 4'b0, 2'd2, 5'b11100, 4'd0);
        cur = '0;
        step(); chk_all("db_run", 4'b0, 2'd0, 5'b0, 4'd1);

        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0010);
        step(); chk_all("mw1", 4'b0, 2'd2, 5'b11100, 4'd1);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0110);
        step(); chk_all("mw2", 4'b0, 2'd2, 5'b11100, 4'd2);
        step(); chk_all("mw3", 4'b0, 2'd2, 5'b11100, 4'd3);
        cur = '0;
        step(); chk_all("mw_exit", 4'b0, 2'd0, 5'b0, 4'd4);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0100);
        step(); chk_all("mw_br", 4'b0, 2'd3, 5'b00011, 4'd4);
        cur = '0;
        step();
        step(); chk_all("mw_fl_done", 4'b0, 2'd0, 5'b0, 4'd4);

        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0001);
        step(); chk("sat_clr", 16'(bus.o_stall_cnt), 16'd0);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0010);
        for (int i = 0; i < 15; i++) step();
        chk("sat14", 16'(bus.o_stall_cnt), 16'd14);
        step(); chk("sat15", 16'(bus.o_stall_cnt), 16'd15);
        for (int i = 0; i < 4; i++) step();
        chk_all("sat_hold", 4'b0, 2'd2, 5'b11100, 4'd15);
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0011);
        step(); chk_all("clr_wins", 4'b0, 2'd2, 5'b11100, 4'd0);
        cur = '0;
        step(); chk_all("sat_exit", 4'b0, 2'd0, 5'b0, 4'd1);

        cur = fi(8'h03, 4'd0, 4'd3, 4'd0, 3'b010, 4'b0010);
        step(); chk_all("mh1", 4'b0001, 2'd2, 5'b11100, 4'd1);
        cur = fi(8'h03, 4'd0, 4'd0, 4'd3, 3'b001, 4'b0010);
        step(); chk_all("mh_hold", 4'b0001, 2'd2, 5'b11100, 4'd2);
        #2 rst_n = 0;
        #1 chk_all("rst_mw", 4'b0, 2'd0, 5'b0, 4'd0);
        rst_n = 1;
        cur = fi(8'h00, 4'd0, 4'd0, 4'd0, 3'b000, 4'b0110);
        step(); chk_all("post_rst", 4'b0, 2'd3, 5'b00011, 4'd0);
        #2 rst_n = 0;
        #1 chk_all("rst_fl", 4'b0, 2'd0, 5'b0, 4'd0);
        rst_n = 1;
        cur = '0;
        step(); chk_all("post_rst2", 4'b0, 2'd0, 5'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
